instruction_sequencer: RTL

- Drives the control side of the register block's interface: owns the 2-bit step counter and supplies desired_source, desired_destination, write_enable, push, pop and inc_enable.
- Fetches each 32-bit instruction as two 16-bit words over a ready-handshake memory port.
- Decodes the instruction, gates writeback on the instruction's effect field and the current flags, and detects halt.
- Sits between instruction memory and the register block / ALU.

---
 rtl/instruction_sequencer_pkg.sv | 73 +++++++
 rtl/instruction_sequencer_if.sv | 14 +
 rtl/instruction_sequencer_fetch_wait_timer.sv | 34 +++
 rtl/instruction_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the step, effect and register codes, the word0 field layout, the
// zero-flag index, and two small helpers: the word0 field decoder and the
// store-condition function.
package instruction_sequencer_pkg;

  typedef enum logic [1:0] {
    STEP_FETCH0    = 2'd0,
    STEP_FETCH1    = 2'd1,
    STEP_EXECUTE   = 2'd2,
    STEP_WRITEBACK = 2'd3
  } step_e;

  typedef enum logic [1:0] {
    EFF_ALWAYS   = 2'd0,
    EFF_ZERO     = 2'd1,
    EFF_NOT_ZERO = 2'd2,
    EFF_NEVER    = 2'd3
  } effect_e;

  typedef enum logic [3:0] {
    REG_PC        = 4'd0,
    REG_FLAGS     = 4'd4,
    REG_BANKING   = 4'd8,
    REG_INTERRUPT = 4'd12
  } reg_code_e;

  // Word0 field bit positions
  localparam int W0_ALU_HI  = 15;
  localparam int W0_ALU_LO  = 12;
  localparam int W0_DST_HI  = 11;
  localparam int W0_DST_LO  = 8;
  localparam int W0_SRC_HI  = 7;
  localparam int W0_SRC_LO  = 4;
  localparam int W0_INC_BIT = 3;
  localparam int W0_PUSH_BIT = 2;
  localparam int W0_EFF_HI  = 1;
  localparam int W0_EFF_LO  = 0;

  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [3:0] dst;
    logic [3:0] src;
    logic       inc;
    logic       push;
    effect_e    effect;
  } word0_t;

  function automatic word0_t decode_word0(input logic [15:0] w);
    word0_t d;
    d.alu_op = w[W0_ALU_HI:W0_ALU_LO];
    d.dst    = w[W0_DST_HI:W0_DST_LO];
    d.src    = w[W0_SRC_HI:W0_SRC_LO];
    d.inc    = w[W0_INC_BIT];
    d.push   = w[W0_PUSH_BIT];
    d.effect = effect_e'(w[W0_EFF_HI:W0_EFF_LO]);
    return d;
  endfunction

  function automatic logic store_condition(input effect_e eff, input logic zero);
    logic ok;
    case (eff)
      EFF_ALWAYS:   ok = 1'b1;
      EFF_ZERO:     ok = zero;
      EFF_NOT_ZERO: ok = ~zero;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Instruction-memory read port.
//   mem_read  : fetch request (master -> slave)
//   mem_addr  : 16-bit fetch address (master -> slave)
//   mem_ready : mem_data valid for mem_addr this cycle (slave -> master)
//   mem_data  : 16-bit read data (slave -> master)
interface instruction_sequencer_if;
  logic        mem_read;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;

  modport master (output mem_read, output mem_addr, input mem_ready, input mem_data);
  modport slave  (input mem_read, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/instruction_sequencer_fetch_wait_timer.sv
// Fetch wait timer: counts cycles a fetch request goes unanswered.
//   clock    : system clock
//   clear    : synchronous clear (driven by the sequencer reset)
//   waiting  : request outstanding and memory not ready this cycle
//   accepted : request answered this cycle; restarts the count
//   expired  : this cycle is the WAIT_LIMIT-th consecutive waiting cycle
module instruction_sequencer_fetch_wait_timer #(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_WIDTH = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic waiting,
  input  logic accepted,
  output logic expired
);

  localparam logic [WAIT_WIDTH-1:0] LAST_WAIT = WAIT_WIDTH'(WAIT_LIMIT - 1);

  logic [WAIT_WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (clear || accepted) begin
      r_count <= '0;
    end else if (waiting) begin
      r_count <= r_count + WAIT_WIDTH'(1);
    end
  end

  // Flag the limit on the waiting cycle itself; a ready memory on that
  // cycle is not waiting, so the accept wins over the timeout.
  assign expired = waiting && (r_count == LAST_WAIT);

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches a two-word instruction, decodes it and
// drives the register-block control signals over a four-step cycle.
//   clock, reset        : system clock, synchronous active-high reset
//   pc, flags           : current PC and flags from the register block
//   mem                 : instruction-memory read port (master side)
//   step                : current step 0-3
//   desired_source/destination : decoded register codes
//   write_enable, write_flags  : writeback / ALU-flag commit (step 3)
//   push, pop, inc_enable      : stack controls (steps 2-3)
//   alu_op, immediate          : decoded operation and second word
//   halted, bus_fault          : stopped / sticky fetch-timeout
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [15:0]              pc,
  input  logic [15:0]              flags,
  instruction_sequencer_if.master  mem,
  output logic [1:0]               step,
  output logic [3:0]               desired_source,
  output logic [3:0]               desired_destination,
  output logic                     write_enable,
  output logic                     push,
  output logic                     pop,
  output logic                     inc_enable,
  output logic                     write_flags,
  output logic [3:0]               alu_op,
  output logic [15:0]              immediate,
  output logic                     halted,
  output logic                     bus_fault
);

  step_e       r_step;
  logic [15:0] r_word0;
  logic [15:0] r_imm;
  logic        r_halted;
  logic        r_bus_fault;
  logic        r_write_enable;
  logic        r_write_flags;

  word0_t      w_dec;
  logic        w_fetching;
  logic        w_accept;
  logic        w_waiting;
  logic        w_expired;
  logic        w_exec;
  logic        w_halt_instr;
  logic        w_store;
  logic        w_unused_flags;

  assign w_dec = decode_word0(r_word0);

  // Reset gates the request directly so nothing is fetched while held.
  assign w_fetching = (r_step == STEP_FETCH0 || r_step == STEP_FETCH1) && !r_halted && !reset;
  assign w_accept   = w_fetching && mem.mem_ready;
  assign w_waiting  = w_fetching && !mem.mem_ready;

  assign mem.mem_read = w_fetching;
  assign mem.mem_addr = !w_fetching              ? 16'h0000 :
                        (r_step == STEP_FETCH1)  ? pc + 16'd1 : pc;

  instruction_sequencer_fetch_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .WAIT_WIDTH (WAIT_WIDTH)
  ) u_wait_timer (
    .clock    (clock),
    .clear    (reset),
    .waiting  (w_waiting),
    .accepted (w_accept),
    .expired  (w_expired)
  );

  // Jump-to-self: PC <- PC + 0 unconditionally.
  assign w_halt_instr = (w_dec.dst == REG_PC) && (w_dec.src == REG_PC) &&
                        (r_imm == 16'h0000) && (w_dec.effect == EFF_ALWAYS);
  assign w_store      = store_condition(w_dec.effect, flags[FLAG_ZERO]);
  assign w_unused_flags = ^flags[15:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_step         <= STEP_FETCH0;
      r_word0        <= '0;
      r_imm          <= '0;
      r_halted       <= 1'b0;
      r_bus_fault    <= 1'b0;
      r_write_enable <= 1'b0;
      r_write_flags  <= 1'b0;
    end else if (!r_halted) begin
      case (r_step)
        // Step 0: fetch word0
        STEP_FETCH0: begin
          if (w_accept) begin
            r_word0 <= mem.mem_data;
            r_step  <= STEP_FETCH1;
          end else if (w_expired) begin
            r_bus_fault <= 1'b1;
            r_halted    <= 1'b1;
          end
        end
        // Step 1: fetch immediate
        STEP_FETCH1: begin
          if (w_accept) begin
            r_imm  <= mem.mem_data;
            r_step <= STEP_FETCH0 == STEP_FETCH0 ? STEP_EXECUTE : STEP_EXECUTE;
          end else if (w_expired) begin
            r_bus_fault <= 1'b1;
            r_halted    <= 1'b1;
          end
        end
        // Step 2: evaluate store condition against this cycle's flags
        STEP_EXECUTE: begin
          r_write_enable <= w_store;
          r_write_flags  <= w_store && (w_dec.alu_op != 4'd0);
          r_step         <= STEP_WRITEBACK;
        end
        // Step 3: writeback, then next fetch or halt
        STEP_WRITEBACK: begin
          r_write_enable <= 1'b0;
          r_write_flags  <= 1'b0;
          r_step         <= STEP_FETCH0;
          if (w_halt_instr) begin
            r_halted <= 1'b1;
          end
        end
      endcase
    end
  end

  assign w_exec = (r_step == STEP_EXECUTE) || (r_step == STEP_WRITEBACK);

  assign step                = r_step;
  assign desired_source      = w_dec.src;
  assign desired_destination = w_dec.dst;
  assign alu_op              = w_dec.alu_op;
  assign immediate           = r_imm;
  assign push                = w_exec && w_dec.push;
  assign pop                 = w_exec && !w_dec.push;
  assign inc_enable          = w_exec && w_dec.inc;
  assign write_enable        = r_write_enable;
  assign write_flags         = r_write_flags;
  assign halted              = r_halted;
  assign bus_fault           = r_bus_fault;

endmodule
